// File: rtl/qsys_tail_ptr_table_responder_pkg.sv
// -----------------------------------------------------------------------------
// qsys_tail_ptr_table_responder_pkg
// Shared types and constants for the queue-system tail-pointer table:
//   - tail-pointer entry / write-request word layouts (32 bits each)
//   - AXI4-Lite response codes
//   - responder FSM state encoding
//   - apply_tail_ptr_write(): the malloc-aware entry update
// -----------------------------------------------------------------------------
package qsys_tail_ptr_table_responder_pkg;

   localparam int QUEUE_TAIL_POINTER_DATALEN = 32;
   localparam int NUM_QUEUES_PER_EGR_PORT    = 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
   localparam logic [3:0] AXI_WSTRB_FULL  = 4'hF;

   // Stored entry, also the read-data word.
   typedef struct packed {
      logic [15:0] tail_ptr;
      logic [14:0] current_page_ptr;
      logic        current_page_valid;
   } queue_tail_pointer_read_t;

   // Write-data word from the congestion manager.
   typedef struct packed {
      logic [15:0] new_tail_ptr;
      logic [14:0] next_page_ptr;
      logic        malloc_approved;
   } queue_tail_pointer_write_t;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_RRESP = 3'd4,
      ST_BRESP = 3'd5
   } tp_state_e;

   // The tail pointer always moves; the current page only advances when a
   // new page was actually allocated for this queue.
   function automatic queue_tail_pointer_read_t apply_tail_ptr_write(
      input queue_tail_pointer_read_t  old,
      input queue_tail_pointer_write_t wr
   );
      queue_tail_pointer_read_t res;
      res          = old;
      res.tail_ptr = wr.new_tail_ptr;
      if (wr.malloc_approved) begin
         res.current_page_ptr   = wr.next_page_ptr;
         res.current_page_valid = 1'b1;
      end else begin
         res.current_page_ptr   = old.current_page_ptr;
         res.current_page_valid = old.current_page_valid;
      end
      return res;
   endfunction

endpackage

// File: rtl/qsys_tail_ptr_table_responder_if.sv
// -----------------------------------------------------------------------------
// qsys_tail_ptr_table_responder_if
// AXI4-Lite channel bundle between the congestion manager (master) and the
// tail-pointer table responder (slave).
//   AW: s_awvalid, s_awready, s_awaddr    W: s_wvalid, s_wready, s_wdata, s_wstrb
//   B : s_bvalid, s_bready, s_bresp       AR: s_arvalid, s_arready, s_araddr
//   R : s_rvalid, s_rready, s_rdata, s_rresp
// -----------------------------------------------------------------------------
interface qsys_tail_ptr_table_responder_if
   import qsys_tail_ptr_table_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = QUEUE_TAIL_POINTER_DATALEN
);
   logic                  s_awvalid;
   logic                  s_awready;
   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [1:0]            s_bresp;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_rvalid;
   logic                  s_rready;
   logic [DATA_WIDTH-1:0] s_rdata;
   logic [1:0]            s_rresp;

   modport slave (
      input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
             s_rvalid, s_rdata, s_rresp
   );

   modport master (
      output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
             s_rvalid, s_rdata, s_rresp
   );
endinterface

// File: rtl/qsys_sp_table.sv
// -----------------------------------------------------------------------------
// qsys_sp_table
// Generic single-port RAM, DEPTH x WIDTH, with a one-cycle registered read.
//   clk   : clock
//   en    : port enable (read when we=0, write when we=1)
//   we    : write enable
//   addr  : entry index
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; held otherwise
// -----------------------------------------------------------------------------
module qsys_sp_table #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // Storage array and registered read port; read data is not updated on writes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[addr] <= wdata;
         end else begin
            rdata_r <= mem_r[addr];
         end
      end
   end

   assign rdata = rdata_r;
endmodule

// File: rtl/qsys_tail_ptr_table_responder.sv
// -----------------------------------------------------------------------------
// qsys_tail_ptr_table_responder
// AXI4-Lite responder holding the per-queue tail-pointer table. Reads return
// the stored entry; writes apply the malloc-aware update as a read-modify-write.
// After every reset the whole table is zeroed before any request is accepted.
//   clk       : clock
//   sreset    : synchronous active-high reset
//   bus       : AXI4-Lite slave port (one transaction outstanding at a time)
//   init_done : high once the zeroing sweep has finished, until next sreset
// -----------------------------------------------------------------------------
module qsys_tail_ptr_table_responder
   import qsys_tail_ptr_table_responder_pkg::*;
#(
   parameter int NUM_QUEUES     = 128,
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            sreset,
   qsys_tail_ptr_table_responder_if.slave  bus,
   output logic                            init_done
);
   localparam int IDX_W   = $clog2(NUM_QUEUES);
   localparam int IDX_LSB = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_QUEUES - 1);
   localparam int DW = QUEUE_TAIL_POINTER_DATALEN;

   if ((AXI_DATA_WIDTH != QUEUE_TAIL_POINTER_DATALEN) ||
       ((1 << IDX_W) != NUM_QUEUES) ||
       ((IDX_LSB + IDX_W) >= AXI_ADDR_WIDTH)) begin : g_param_error
      $error("qsys_tail_ptr_table_responder: unsupported parameter set");
   end

   tp_state_e                 state_r, state_n;
   logic [IDX_W-1:0]          init_cnt_r;
   logic                      init_done_r;
   logic [IDX_W-1:0]          idx_r;
   logic                      wr_ok_r;
   logic                      rd_oor_r;
   queue_tail_pointer_write_t wdata_r;
   logic [1:0]                bresp_r;
   logic [1:0]                rresp_r;
   logic [DW-1:0]             rdata_r;

   logic [IDX_W-1:0] aw_idx_s, ar_idx_s;
   logic             aw_oor_s, ar_oor_s;
   logic             wr_req_s, wr_acc_s, rd_acc_s;
   logic             ram_en_s, ram_we_s;
   logic [IDX_W-1:0] ram_addr_s;
   logic [DW-1:0]    ram_wdata_s, ram_rdata_s;
   logic             addr_lsb_unused_s;

   // Byte offset inside a word carries no meaning here.
   assign addr_lsb_unused_s = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};

   // Any set bit above the index field addresses a queue that does not exist.
   assign aw_idx_s = bus.s_awaddr[IDX_LSB +: IDX_W];
   assign ar_idx_s = bus.s_araddr[IDX_LSB +: IDX_W];
   assign aw_oor_s = (bus.s_awaddr >> (IDX_LSB + IDX_W)) != {AXI_ADDR_WIDTH{1'b0}};
   assign ar_oor_s = (bus.s_araddr >> (IDX_LSB + IDX_W)) != {AXI_ADDR_WIDTH{1'b0}};

   // AW and W are only taken together; a complete write request blocks AR.
   assign wr_req_s = bus.s_awvalid & bus.s_wvalid;
   assign wr_acc_s = (state_r == ST_IDLE) & wr_req_s;
   assign rd_acc_s = (state_r == ST_IDLE) & bus.s_arvalid & ~wr_req_s;

   assign bus.s_awready = wr_acc_s;
   assign bus.s_wready  = wr_acc_s;
   assign bus.s_arready = rd_acc_s;
   assign bus.s_bvalid  = (state_r == ST_BRESP);
   assign bus.s_bresp   = bresp_r;
   assign bus.s_rvalid  = (state_r == ST_RRESP);
   assign bus.s_rdata   = rdata_r;
   assign bus.s_rresp   = rresp_r;
   assign init_done     = init_done_r;

   qsys_sp_table #(
      .DEPTH (NUM_QUEUES),
      .WIDTH (DW)
   ) u_table (
      .clk   (clk),
      .en    (ram_en_s),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r == LAST_IDX) state_n = ST_IDLE;
            else                        state_n = ST_INIT;
         end
         ST_IDLE: begin
            if (wr_acc_s)      state_n = ST_WRITE;
            else if (rd_acc_s) state_n = ST_READ;
            else               state_n = ST_IDLE;
         end
         ST_WRITE: state_n = ST_BRESP;
         ST_READ:  state_n = ST_RRESP;
         ST_RRESP: begin
            if (bus.s_rready) state_n = ST_IDLE;
            else              state_n = ST_RRESP;
         end
         ST_BRESP: begin
            if (bus.s_bready) state_n = ST_IDLE;
            else              state_n = ST_BRESP;
         end
         default: state_n = ST_INIT;
      endcase
   end

   // Table port steering: sweep writes, accept-cycle fetch, WRITE-cycle update.
   always_comb begin
      ram_en_s    = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = {IDX_W{1'b0}};
      ram_wdata_s = {DW{1'b0}};
      case (state_r)
         ST_INIT: begin
            ram_en_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = init_cnt_r;
         end
         ST_IDLE: begin
            if (wr_acc_s) begin
               ram_en_s   = 1'b1;
               ram_addr_s = aw_idx_s;
            end else if (rd_acc_s) begin
               ram_en_s   = 1'b1;
               ram_addr_s = ar_idx_s;
            end else begin
               ram_en_s = 1'b0;
            end
         end
         ST_WRITE: begin
            // The old entry fetched in the accept cycle is on ram_rdata_s now.
            ram_en_s    = 1'b1;
            ram_we_s    = wr_ok_r;
            ram_addr_s  = idx_r;
            ram_wdata_s = apply_tail_ptr_write(ram_rdata_s, wdata_r);
         end
         default: ram_en_s = 1'b0;
      endcase
   end

   // State register, sweep counter, request capture and response registers.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_r     <= ST_INIT;
         init_cnt_r  <= {IDX_W{1'b0}};
         init_done_r <= 1'b0;
         idx_r       <= {IDX_W{1'b0}};
         wr_ok_r     <= 1'b0;
         rd_oor_r    <= 1'b0;
         wdata_r     <= {DW{1'b0}};
         bresp_r     <= AXI_RESP_OKAY;
         rresp_r     <= AXI_RESP_OKAY;
         rdata_r     <= {DW{1'b0}};
      end else begin
         state_r <= state_n;
         case (state_r)
            ST_INIT: begin
               init_cnt_r <= init_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
               if (init_cnt_r == LAST_IDX) init_done_r <= 1'b1;
            end
            ST_IDLE: begin
               if (wr_acc_s) begin
                  idx_r   <= aw_idx_s;
                  wr_ok_r <= ~aw_oor_s & (bus.s_wstrb == AXI_WSTRB_FULL);
                  wdata_r <= bus.s_wdata;
               end else if (rd_acc_s) begin
                  idx_r    <= ar_idx_s;
                  rd_oor_r <= ar_oor_s;
               end
            end
            ST_WRITE: begin
               bresp_r <= wr_ok_r ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            ST_READ: begin
               rdata_r <= rd_oor_r ? {DW{1'b0}} : ram_rdata_s;
               rresp_r <= rd_oor_r ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_qsys_tail_ptr_table_responder.sv
// -----------------------------------------------------------------------------
// tb_qsys_tail_ptr_table_responder
// Directed scenarios against the tail-pointer table responder. Expected
// responses are queued when a request is issued and popped when the DUT
// answers. All tasks start and end 1 time unit after a rising clock edge.
// -----------------------------------------------------------------------------
module tb_qsys_tail_ptr_table_responder;
   import qsys_tail_ptr_table_responder_pkg::*;

   localparam int NQ      = 128;
   localparam int TIMEOUT = 300;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic clk = 1'b0;
   logic sreset;
   logic init_done;
   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   qsys_tail_ptr_table_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

   qsys_tail_ptr_table_responder #(
      .NUM_QUEUES     (NQ),
      .AXI_ADDR_WIDTH (16),
      .AXI_DATA_WIDTH (32)
   ) dut (
      .clk       (clk),
      .sreset    (sreset),
      .bus       (bus),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.s_awvalid = 1'b0;  bus.s_awaddr = 16'h0;
      bus.s_wvalid  = 1'b0;  bus.s_wdata  = 32'h0;  bus.s_wstrb = 4'h0;
      bus.s_bready  = 1'b0;
      bus.s_arvalid = 1'b0;  bus.s_araddr = 16'h0;
      bus.s_rready  = 1'b0;
   endtask

   // Full write transaction; lat = cycles from accept cycle to bvalid.
   task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output int lat, output int acc_wait);
      bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      resp = 2'bxx; lat = -1; acc_wait = 0;
      @(negedge clk);
      while (!(bus.s_awready && bus.s_wready) && acc_wait < TIMEOUT) begin
         acc_wait++;
         @(negedge clk);
      end
      if (acc_wait >= TIMEOUT) begin
         vectors++; miscompares++;
         $display("FAIL write_accept addr=%h: no awready/wready within %0d cycles, required accept", addr, TIMEOUT);
         bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.s_bvalid && lat < TIMEOUT);
      if (bus.s_bvalid) resp = bus.s_bresp;
      else              lat = -1;
      @(posedge clk); #1;
      bus.s_bready = 1'b0;
   endtask

   // Full read transaction; lat = cycles from accept cycle to rvalid.
   task automatic axi_read(input logic [15:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output int acc_wait);
      bus.s_araddr = addr; bus.s_arvalid = 1'b1;
      data = 32'hxxxxxxxx; resp = 2'bxx; lat = -1; acc_wait = 0;
      @(negedge clk);
      while (!bus.s_arready && acc_wait < TIMEOUT) begin
         acc_wait++;
         @(negedge clk);
      end
      if (acc_wait >= TIMEOUT) begin
         vectors++; miscompares++;
         $display("FAIL read_accept addr=%h: no arready within %0d cycles, required accept", addr, TIMEOUT);
         bus.s_arvalid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.s_rvalid && lat < TIMEOUT);
      if (bus.s_rvalid) begin
         data = bus.s_rdata; resp = bus.s_rresp;
      end else begin
         lat = -1;
      end
      @(posedge clk); #1;
      bus.s_rready = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      logic ready_seen;
      sreset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid, init_done} !== 6'b0)
         begin miscompares++; $display("FAIL reset_ctrl: aw/w/ar/b/r/done=%b, required 000000",
            {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid, init_done}); end
      vectors++;
      if (bus.s_rdata !== 32'h0 || bus.s_bresp !== 2'd0 || bus.s_rresp !== 2'd0)
         begin miscompares++; $display("FAIL reset_data: rdata=%h bresp=%0d rresp=%0d, required 0/0/0",
            bus.s_rdata, bus.s_bresp, bus.s_rresp); end
      // Requests held during the sweep must not be accepted.
      sreset = 1'b0;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_wstrb = 4'hF; bus.s_arvalid = 1'b1;
      cyc = 0; ready_seen = 1'b0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc <= 10 && (bus.s_awready || bus.s_wready || bus.s_arready)) ready_seen = 1'b1;
         if (cyc == 10) idle_inputs();
      end while (!init_done && cyc < TIMEOUT);
      vectors++;
      if (ready_seen !== 1'b0) begin miscompares++; $display("FAIL init_ready: ready seen during sweep=%b, required 0", ready_seen); end
      vectors++;
      if (cyc !== 128) begin miscompares++; $display("FAIL init_cycles: %0d cycles to init_done, required 128", cyc); end
   endtask

   task automatic test_sweep_readback();
      logic [31:0] d; logic [1:0] r; int lat, w; exp_t e; int bad_lat;
      bad_lat = 0;
      for (int q = 0; q < NQ; q++) begin
         exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
         axi_read(16'(q * 4), d, r, lat, w);
         e = exp_q.pop_front();
         vectors++;
         if (d !== e.data || r !== e.resp) begin miscompares++;
            $display("FAIL sweep_q%0d: rdata=%h rresp=%0d, required %h/%0d", q, d, r, e.data, e.resp); end
         if (lat != 2) bad_lat++;
      end
      vectors++;
      if (bad_lat !== 0) begin miscompares++; $display("FAIL sweep_latency: %0d reads not at 2 cycles, required 0", bad_lat); end
   endtask

   task automatic test_write_malloc();
      logic [31:0] d; logic [1:0] r; int lat, w; exp_t e;
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      axi_write(16'h0014, {16'h1234, 15'h0ABC, 1'b1}, 4'hF, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e.resp) begin miscompares++; $display("FAIL malloc_bresp: %0d, required %0d", r, e.resp); end
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL malloc_blat: %0d, required 2", lat); end
      exp_q.push_back(exp_t'{data: 32'h12341579, resp: AXI_RESP_OKAY});
      axi_read(16'h0014, d, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.data || r !== e.resp) begin miscompares++;
         $display("FAIL malloc_read: rdata=%h rresp=%0d, required %h/%0d", d, r, e.data, e.resp); end
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL malloc_rlat: %0d, required 2", lat); end
   endtask

   task automatic test_write_no_malloc();
      logic [31:0] d; logic [1:0] r; int lat, w; exp_t e;
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      axi_write(16'h0014, {16'h2000, 15'h7FFF, 1'b0}, 4'hF, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e.resp) begin miscompares++; $display("FAIL nomalloc_bresp: %0d, required %0d", r, e.resp); end
      exp_q.push_back(exp_t'{data: 32'h20001579, resp: AXI_RESP_OKAY});
      axi_read(16'h0014, d, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.data || r !== e.resp) begin miscompares++;
         $display("FAIL nomalloc_read: rdata=%h rresp=%0d, required %h/%0d", d, r, e.data, e.resp); end
   endtask

   task automatic test_arbitration();
      logic [31:0] d; logic [1:0] r; int lat, w, n; exp_t e; logic stall_bad;
      bus.s_awaddr = 16'h0024; bus.s_wdata = {16'hBEEF, 15'h0123, 1'b1}; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      bus.s_araddr = 16'h0024; bus.s_arvalid = 1'b1;
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      @(negedge clk);
      vectors++;
      if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b110) begin miscompares++;
         $display("FAIL arb_accept: aw/w/ar ready=%b, required 110", {bus.s_awready, bus.s_wready, bus.s_arready}); end
      @(posedge clk); #1;
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
      n = 0; stall_bad = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (bus.s_arready) stall_bad = 1'b1;
      end while (!bus.s_bvalid && n < TIMEOUT);
      e = exp_q.pop_front();
      vectors++;
      if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== e.resp) begin miscompares++;
         $display("FAIL arb_bresp: bvalid=%b bresp=%0d, required 1/%0d", bus.s_bvalid, bus.s_bresp, e.resp); end
      vectors++;
      if (stall_bad !== 1'b0) begin miscompares++; $display("FAIL arb_ar_stall: arready during write=%b, required 0", stall_bad); end
      @(posedge clk); #1;
      bus.s_bready = 1'b0;
      exp_q.push_back(exp_t'{data: 32'hBEEF0247, resp: AXI_RESP_OKAY});
      axi_read(16'h0024, d, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.data || r !== e.resp) begin miscompares++;
         $display("FAIL arb_read: rdata=%h rresp=%0d, required %h/%0d", d, r, e.data, e.resp); end
      vectors++;
      if (w !== 0) begin miscompares++; $display("FAIL arb_read_wait: %0d cycles, required 0", w); end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic [1:0] r; int lat, w; exp_t e;
      logic [15:0] waddr [2];
      logic [3:0]  wstrb [2];
      logic [15:0] raddr [5];
      logic [31:0] rexp  [5];
      logic [1:0]  rrsp  [5];
      waddr = '{16'h0200, 16'h0014};
      wstrb = '{4'hF, 4'h3};
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_SLVERR});
         axi_write(waddr[i], {16'hDEAD, 15'h1111, 1'b1}, wstrb[i], r, lat, w);
         e = exp_q.pop_front();
         vectors++;
         if (r !== e.resp) begin miscompares++;
            $display("FAIL err_bresp_%0d: addr=%h bresp=%0d, required %0d", i, waddr[i], r, e.resp); end
      end
      raddr = '{16'h0000, 16'h0014, 16'h0200, 16'h0224, 16'h0016};
      rexp  = '{32'h0, 32'h20001579, 32'h0, 32'h0, 32'h20001579};
      rrsp  = '{AXI_RESP_OKAY, AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_SLVERR, AXI_RESP_OKAY};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exp_t'{data: rexp[i], resp: rrsp[i]});
         axi_read(raddr[i], d, r, lat, w);
         e = exp_q.pop_front();
         vectors++;
         if (d !== e.data || r !== e.resp) begin miscompares++;
            $display("FAIL err_read_%h: rdata=%h rresp=%0d, required %h/%0d", raddr[i], d, r, e.data, e.resp); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r; int lat, w; exp_t e;
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      axi_write(16'h01FC, {16'hFFFF, 15'h7FFF, 1'b1}, 4'hF, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e.resp) begin miscompares++; $display("FAIL b2b_bresp_q127: %0d, required %0d", r, e.resp); end
      exp_q.push_back(exp_t'{data: 32'hFFFFFFFF, resp: AXI_RESP_OKAY});
      axi_read(16'h01FC, d, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.data || r !== e.resp || w !== 0) begin miscompares++;
         $display("FAIL b2b_read_q127: rdata=%h rresp=%0d wait=%0d, required %h/%0d/0", d, r, w, e.data, e.resp); end
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      axi_write(16'h0000, {16'h0001, 15'h0002, 1'b0}, 4'hF, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e.resp || w !== 0) begin miscompares++;
         $display("FAIL b2b_write_q0: bresp=%0d wait=%0d, required %0d/0", r, w, e.resp); end
      exp_q.push_back(exp_t'{data: 32'h00010000, resp: AXI_RESP_OKAY});
      axi_read(16'h0000, d, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e.data || r !== e.resp) begin miscompares++;
         $display("FAIL b2b_read_q0: rdata=%h rresp=%0d, required %h/%0d", d, r, e.data, e.resp); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d; logic [1:0] r; int lat, w, n, cyc; exp_t e;
      logic [15:0] chk_addr [3];
      exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
      axi_write(16'h000C, {16'h3333, 15'h0333, 1'b1}, 4'hF, r, lat, w);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e.resp) begin miscompares++; $display("FAIL rst_pre_bresp: %0d, required %0d", r, e.resp); end
      // Read queue 3 but never take the response.
      bus.s_araddr = 16'h000C; bus.s_arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.s_arready && n < TIMEOUT) begin n++; @(negedge clk); end
      @(posedge clk); #1;
      bus.s_arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s_rvalid && n < TIMEOUT);
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== 32'h33330667) begin miscompares++;
         $display("FAIL rst_rresp_hold: rvalid=%b rdata=%h, required 1/33330667", bus.s_rvalid, bus.s_rdata); end
      @(posedge clk); #1;
      sreset = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.s_rvalid !== 1'b0 || init_done !== 1'b0 || bus.s_rdata !== 32'h0) begin miscompares++;
         $display("FAIL rst_drop: rvalid=%b init_done=%b rdata=%h, required 0/0/0", bus.s_rvalid, init_done, bus.s_rdata); end
      sreset = 1'b0;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!init_done && cyc < TIMEOUT);
      vectors++;
      if (cyc !== 128) begin miscompares++; $display("FAIL rst_init_cycles: %0d, required 128", cyc); end
      chk_addr = '{16'h000C, 16'h0014, 16'h01FC};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exp_t'{data: 32'h0, resp: AXI_RESP_OKAY});
         axi_read(chk_addr[i], d, r, lat, w);
         e = exp_q.pop_front();
         vectors++;
         if (d !== e.data || r !== e.resp) begin miscompares++;
            $display("FAIL rst_zeroed_%h: rdata=%h rresp=%0d, required %h/%0d", chk_addr[i], d, r, e.data, e.resp); end
      end
   endtask

   initial begin
      test_reset();
      test_sweep_readback();
      test_write_malloc();
      test_write_no_malloc();
      test_arbitration();
      test_errors();
      test_back_to_back();
      test_reset_mid_read();
      vectors++;
      if (exp_q.size() !== 0) begin miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
